// File: rtl/ahbl_sram_bridge_pkg.sv
// ahbl_sram_bridge_pkg
//   Shared AHB-Lite definitions: HTRANS/HSIZE encodings, the error FSM
//   state type of the SRAM bridge, and a byte-lane enable helper that any
//   AHB slave can reuse.
package ahbl_sram_bridge_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE = 2'b00,
        HTRANS_BUSY = 2'b01,
        HTRANS_NSEQ = 2'b10,
        HTRANS_SEQ  = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE   = 3'd0;
    localparam logic [2:0] HSIZE_HALF   = 3'd1;
    localparam logic [2:0] HSIZE_WORD   = 3'd2;
    localparam logic [2:0] HSIZE_DWORD  = 3'd3;
    localparam logic [2:0] HSIZE_QWORD  = 3'd4;
    localparam logic [2:0] HSIZE_OWORD  = 3'd5;
    localparam logic [2:0] HSIZE_512    = 3'd6;
    localparam logic [2:0] HSIZE_1024   = 3'd7;

    typedef enum logic [1:0] {
        ERR_IDLE = 2'd0,
        ERR_ERR1 = 2'd1,
        ERR_ERR2 = 2'd2
    } err_state_e;

    // Returns 1 when byte lane 'lane' is written by a transfer of size
    // 'hsize' at byte address 'addr_lo' on a bus of 2**bytes_log2 lanes.
    // Misaligned addresses are aligned down to the transfer size.
    function automatic logic lane_en(input logic [2:0]  hsize,
                                     input logic [6:0]  addr_lo,
                                     input int unsigned lane,
                                     input int unsigned bytes_log2);
        int unsigned size_b;
        int unsigned base;
        size_b = 32'd1 << hsize;
        base   = (32'(addr_lo) & ((32'd1 << bytes_log2) - 32'd1)) & ~(size_b - 32'd1);
        return (lane >= base) && (lane < base + size_b);
    endfunction

endpackage

// File: rtl/ahbl_sram_bridge_if.sv
// ahbl_sram_bridge_if
//   AHB-Lite slave port bundle.
//   master modport: drives haddr/hwrite/htrans/hsize/hwdata/hready,
//                   receives hready_resp/hresp/hrdata.
//   slave modport : the mirror image.
interface ahbl_sram_bridge_if #(
    parameter int W_DATA = 32,
    parameter int W_ADDR = 32
);
    logic              hready;
    logic              hready_resp;
    logic              hresp;
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [W_DATA-1:0] hwdata;
    logic [W_DATA-1:0] hrdata;

    modport master (
        output hready, haddr, hwrite, htrans, hsize, hwdata,
        input  hready_resp, hresp, hrdata
    );

    modport slave (
        input  hready, haddr, hwrite, htrans, hsize, hwdata,
        output hready_resp, hresp, hrdata
    );
endinterface

// File: rtl/ahbl_sram_bridge_wbuf.sv
// ahbl_sram_bridge_wbuf
//   One-entry write buffer plus read-forwarding merge.
//   capture_i : load addr/mask/data this edge (wins over drain_i)
//   drain_i   : buffer contents go to the SRAM this cycle; empty after edge
//   valid_o/addr_o/mask_o/data_o : buffered write
//   rd_addr_i/sram_rdata_i -> rdata_o : SRAM read data with buffered bytes
//                                       of a matching word substituted
module ahbl_sram_bridge_wbuf #(
    parameter int W_DATA      = 32,
    parameter int W_SRAM_ADDR = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   capture_i,
    input  logic                   drain_i,
    input  logic [W_SRAM_ADDR-1:0] cap_addr_i,
    input  logic [W_DATA/8-1:0]    cap_mask_i,
    input  logic [W_DATA-1:0]      cap_data_i,
    output logic                   valid_o,
    output logic [W_SRAM_ADDR-1:0] addr_o,
    output logic [W_DATA/8-1:0]    mask_o,
    output logic [W_DATA-1:0]      data_o,
    input  logic [W_SRAM_ADDR-1:0] rd_addr_i,
    input  logic [W_DATA-1:0]      sram_rdata_i,
    output logic [W_DATA-1:0]      rdata_o
);
    localparam int N_BYTES = W_DATA / 8;

    logic                   valid_q, valid_d;
    logic [W_SRAM_ADDR-1:0] addr_q;
    logic [N_BYTES-1:0]     mask_q;
    logic [W_DATA-1:0]      data_q;

    always_comb begin
        valid_d = valid_q;
        if (capture_i)    valid_d = 1'b1;
        else if (drain_i) valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            mask_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (capture_i) begin
                addr_q <= cap_addr_i;
                mask_q <= cap_mask_i;
                data_q <= cap_data_i;
            end
        end
    end

    always_comb begin
        rdata_o = sram_rdata_i;
        for (int i = 0; i < N_BYTES; i++) begin
            if (valid_q && (addr_q == rd_addr_i) && mask_q[i])
                rdata_o[8*i +: 8] = data_q[8*i +: 8];
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign mask_o  = mask_q;
    assign data_o  = data_q;
endmodule

// File: rtl/ahbl_sram_bridge.sv
// ahbl_sram_bridge
//   Zero-wait-state AHB-Lite slave driving one single-port synchronous SRAM
//   (byte write enables, 1-cycle read latency).
//   clk, rst_n         : clock, asynchronous active-low reset
//   ahbls (slave)      : AHB-Lite slave port
//   sram_addr/wen/wdata: SRAM command port; sram_rdata valid 1 cycle later
//   dbg_err_state_o    : current error FSM state
module ahbl_sram_bridge
    import ahbl_sram_bridge_pkg::*;
#(
    parameter int W_DATA      = 32,
    parameter int W_ADDR      = 32,
    parameter int DEPTH       = 2048,
    parameter int W_SRAM_ADDR = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ahbl_sram_bridge_if.slave      ahbls,
    output logic [W_SRAM_ADDR-1:0] sram_addr,
    output logic [W_DATA/8-1:0]    sram_wen,
    output logic [W_DATA-1:0]      sram_wdata,
    input  logic [W_DATA-1:0]      sram_rdata,
    output err_state_e             dbg_err_state_o
);
    localparam int N_BYTES = W_DATA / 8;
    localparam int BL      = $clog2(N_BYTES);

    // Address phase decode. ERR1 stalls the bus, so nothing is accepted there.
    logic                   aph, aph_illegal, aph_ok, rd_aph, wr_aph;
    logic [W_SRAM_ADDR-1:0] aph_word;
    logic [N_BYTES-1:0]     aph_mask;
    err_state_e             err_q, err_d;

    assign aph         = ahbls.hready && ahbls.htrans[1] && (err_q != ERR_ERR1);
    assign aph_illegal = aph && (ahbls.hsize > 3'(BL));
    assign aph_ok      = aph && !aph_illegal;
    assign rd_aph      = aph_ok && !ahbls.hwrite;
    assign wr_aph      = aph_ok && ahbls.hwrite;
    assign aph_word    = ahbls.haddr[BL +: W_SRAM_ADDR];

    always_comb begin
        aph_mask = '0;
        for (int i = 0; i < N_BYTES; i++)
            aph_mask[i] = lane_en(ahbls.hsize, ahbls.haddr[6:0], i, BL);
    end

    // Registered data-phase context.
    logic                   dp_write_q, dp_read_q, wr_dp;
    logic [W_SRAM_ADDR-1:0] dp_addr_q;
    logic [N_BYTES-1:0]     dp_mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_write_q <= 1'b0;
            dp_read_q  <= 1'b0;
            dp_addr_q  <= '0;
            dp_mask_q  <= '0;
        end else if (ahbls.hready) begin
            dp_write_q <= wr_aph;
            dp_read_q  <= rd_aph;
            if (aph_ok) begin
                dp_addr_q <= aph_word;
                dp_mask_q <= aph_mask;
            end
        end
    end

    assign wr_dp = dp_write_q && ahbls.hready;

    // SRAM port arbitration: read aph > buffer drain > direct write.
    // A write data phase that cannot use the port (read aph, or the buffer
    // is draining) is captured into the buffer instead.
    logic                   wb_capture, wb_drain, wb_valid;
    logic [W_SRAM_ADDR-1:0] wb_addr, sram_addr_q, sram_addr_d;
    logic [N_BYTES-1:0]     wb_mask;
    logic [W_DATA-1:0]      wb_data;

    always_comb begin
        sram_addr_d = sram_addr_q;
        sram_wen    = '0;
        sram_wdata  = ahbls.hwdata;
        wb_capture  = 1'b0;
        wb_drain    = 1'b0;
        if (rd_aph) begin
            sram_addr_d = aph_word;
            wb_capture  = wr_dp;
        end else if (wb_valid) begin
            sram_addr_d = wb_addr;
            sram_wen    = wb_mask;
            sram_wdata  = wb_data;
            wb_drain    = 1'b1;
            wb_capture  = wr_dp;
        end else if (wr_dp) begin
            sram_addr_d = dp_addr_q;
            sram_wen    = dp_mask_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sram_addr_q <= '0;
        else        sram_addr_q <= sram_addr_d;
    end

    assign sram_addr = sram_addr_d;

    ahbl_sram_bridge_wbuf #(
        .W_DATA      (W_DATA),
        .W_SRAM_ADDR (W_SRAM_ADDR)
    ) u_wbuf (
        .clk          (clk),
        .rst_n        (rst_n),
        .capture_i    (wb_capture),
        .drain_i      (wb_drain),
        .cap_addr_i   (dp_addr_q),
        .cap_mask_i   (dp_mask_q),
        .cap_data_i   (ahbls.hwdata),
        .valid_o      (wb_valid),
        .addr_o       (wb_addr),
        .mask_o       (wb_mask),
        .data_o       (wb_data),
        .rd_addr_i    (dp_addr_q),
        .sram_rdata_i (sram_rdata),
        .rdata_o      (ahbls.hrdata)
    );

    // Error FSM: two-cycle AHB ERROR response for an illegal hsize.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= ERR_IDLE;
        else        err_q <= err_d;
    end

    always_comb begin
        err_d             = err_q;
        ahbls.hready_resp = 1'b1;
        ahbls.hresp       = 1'b0;
        case (err_q)
            ERR_IDLE: if (aph_illegal) err_d = ERR_ERR1;
            ERR_ERR1: begin
                ahbls.hready_resp = 1'b0;
                ahbls.hresp       = 1'b1;
                err_d             = ERR_ERR2;
            end
            ERR_ERR2: begin
                ahbls.hresp = 1'b1;
                err_d       = aph_illegal ? ERR_ERR1 : ERR_IDLE;
            end
            default: err_d = ERR_IDLE;
        endcase
    end

    assign dbg_err_state_o = err_q;
endmodule

// File: tb/tb_ahbl_sram_bridge.sv
module tb_ahbl_sram_bridge;
    import ahbl_sram_bridge_pkg::*;

    localparam int W_DATA = 32;
    localparam int W_ADDR = 32;
    localparam int DEPTH  = 2048;
    localparam int W_SA   = $clog2(DEPTH);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ahbl_sram_bridge_if #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) bus ();
    assign bus.hready = bus.hready_resp;

    logic [W_SA-1:0]   sram_addr;
    logic [3:0]        sram_wen;
    logic [W_DATA-1:0] sram_wdata;
    logic [W_DATA-1:0] sram_rdata;
    err_state_e        dbg_state;

    ahbl_sram_bridge #(
        .W_DATA (W_DATA),
        .W_ADDR (W_ADDR),
        .DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ahbls           (bus),
        .sram_addr       (sram_addr),
        .sram_wen        (sram_wen),
        .sram_wdata      (sram_wdata),
        .sram_rdata      (sram_rdata),
        .dbg_err_state_o (dbg_state)
    );

    // SRAM behavioural model: synchronous, byte write enables, 1-cycle read.
    logic [31:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (sram_wen[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        sram_rdata <= sram_mem[sram_addr];
    end

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic        pend_w, pend_r;
    logic [31:0] pend_wd;
    logic        s_ready, s_resp;
    logic [3:0]  s_wen;
    logic [31:0] s_addr, s_wdata, s_rdata, s_state;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // A write of 2**sz bytes lands on the aligned-down byte lanes of its word.
    task automatic ref_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int n, off, idx;
        n   = 1 << sz;
        off = (int'(a[1:0]) / n) * n;
        idx = word_of(a);
        for (int b = off; b < off + n; b++) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
    endtask

    // ---------------- driver ----------------
    // One bus cycle: present an address phase (or IDLE) plus the data phase
    // of the previous transfer, sample outputs on the falling edge.
    task automatic bus_cycle(input logic v, input logic w, input logic [31:0] a,
                             input logic [2:0] sz, input logic [31:0] wd);
        logic legal;
        logic [31:0] e;
        legal       = v && (sz <= 3'd2);
        bus.hwdata  = pend_w ? pend_wd : $urandom;
        bus.htrans  = v ? HTRANS_NSEQ : HTRANS_IDLE;
        bus.hwrite  = w;
        bus.haddr   = a;
        bus.hsize   = sz;
        if (legal) begin
            if (w) ref_write(a, sz, wd);
            else   exp_q.push_back(ref_mem[word_of(a)]);
        end
        @(negedge clk);
        s_ready = bus.hready_resp;
        s_resp  = bus.hresp;
        s_wen   = sram_wen;
        s_addr  = 32'(sram_addr);
        s_wdata = sram_wdata;
        s_state = 32'(dbg_state);
        s_rdata = bus.hrdata;
        if (pend_r) begin
            e = exp_q.pop_front();
            check("rdata", bus.hrdata, e);
        end
        pend_w  = legal && w;
        pend_r  = legal && !w;
        pend_wd = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        bus_cycle(1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] old_word;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram_mem[i] = 32'h1000_0000 + i * 32'h0001_0203;
            ref_mem[i]  = 32'h1000_0000 + i * 32'h0001_0203;
        end
        sram_mem[5] = 32'hDEADBEEF;
        ref_mem[5]  = 32'hDEADBEEF;
        pend_w = 1'b0; pend_r = 1'b0; pend_wd = '0;
        bus.htrans = HTRANS_IDLE; bus.hwrite = 1'b0; bus.haddr = '0;
        bus.hsize = 3'd2; bus.hwdata = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hready", 32'(bus.hready_resp), 32'd1);
        check("rst_hresp",  32'(bus.hresp),       32'd0);
        check("rst_wen",    32'(sram_wen),        32'd0);
        check("rst_state",  32'(dbg_state),       32'(ERR_IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Read of preloaded word 5
        bus_cycle(1'b1, 1'b0, 32'h14, 3'd2, 32'h0);
        check("rd_aph_ready", 32'(s_ready), 32'd1);
        check("rd_aph_addr",  s_addr, 32'd5);
        idle_cycle();
        check("rd_deadbeef", s_rdata, 32'hDEADBEEF);
        check("rd_dp_ready", 32'(s_ready), 32'd1);

        // Write then back-to-back read, forwarded from the buffer
        bus_cycle(1'b1, 1'b1, 32'h20, 3'd2, 32'h11223344);
        bus_cycle(1'b1, 1'b0, 32'h20, 3'd2, 32'h0);
        check("wr_rd_aph_wen",  32'(s_wen), 32'h0);
        check("wr_rd_aph_addr", s_addr,     32'd8);
        idle_cycle();
        check("fwd_word",     s_rdata,    32'h11223344);
        check("commit_wen",   32'(s_wen), 32'hF);
        check("commit_addr",  s_addr,     32'd8);
        check("commit_wdata", s_wdata,    32'h11223344);

        // Byte write into a zeroed word, then word read
        bus_cycle(1'b1, 1'b1, 32'h20, 3'd2, 32'h0);
        idle_cycle();
        check("zero_commit_wen", 32'(s_wen), 32'hF);
        bus_cycle(1'b1, 1'b1, 32'h22, 3'd0, 32'h00AB0000);
        bus_cycle(1'b1, 1'b0, 32'h20, 3'd2, 32'h0);
        idle_cycle();
        check("byte_fwd",        s_rdata,    32'h00AB0000);
        check("byte_commit_wen", 32'(s_wen), 32'h4);

        // W W R: direct commit, buffered commit, unrelated read
        bus_cycle(1'b1, 1'b1, 32'h0, 3'd2, 32'hA5A50001);
        bus_cycle(1'b1, 1'b1, 32'h4, 3'd2, 32'h5A5A0002);
        check("wwr_direct_wen",  32'(s_wen), 32'hF);
        check("wwr_direct_addr", s_addr,     32'd0);
        bus_cycle(1'b1, 1'b0, 32'h0, 3'd2, 32'h0);
        check("wwr_rd_wen", 32'(s_wen), 32'h0);
        idle_cycle();
        check("wwr_rdata",      s_rdata,    32'hA5A50001);
        check("wwr_drain_wen",  32'(s_wen), 32'hF);
        check("wwr_drain_addr", s_addr,     32'd1);
        idle_cycle();

        // Illegal hsize: two-cycle ERROR, no SRAM write
        bus_cycle(1'b1, 1'b1, 32'h30, 3'd3, 32'hFFFFFFFF);
        check("err_aph_ready", 32'(s_ready), 32'd1);
        check("err_aph_wen",   32'(s_wen),   32'h0);
        idle_cycle();
        check("err1_ready", 32'(s_ready), 32'd0);
        check("err1_resp",  32'(s_resp),  32'd1);
        check("err1_state", s_state,      32'(ERR_ERR1));
        check("err1_wen",   32'(s_wen),   32'h0);
        idle_cycle();
        check("err2_ready", 32'(s_ready), 32'd1);
        check("err2_resp",  32'(s_resp),  32'd1);
        check("err2_wen",   32'(s_wen),   32'h0);
        idle_cycle();
        check("err_done_resp", 32'(s_resp), 32'd0);
        bus_cycle(1'b1, 1'b0, 32'h30, 3'd2, 32'h0);
        idle_cycle();

        // High address bits alias onto word 5
        bus_cycle(1'b1, 1'b0, 32'h0000_2014, 3'd2, 32'h0);
        idle_cycle();
        check("alias_rdata", s_rdata, 32'hDEADBEEF);

        // Reset while a write sits in the buffer
        old_word = ref_mem[16];
        bus_cycle(1'b1, 1'b1, 32'h40, 3'd2, 32'hCAFEF00D);
        bus_cycle(1'b1, 1'b0, 32'h44, 3'd2, 32'h0);
        bus.htrans = HTRANS_IDLE;
        rst_n = 1'b0;
        #1;
        check("rst_mid_wen",   32'(sram_wen),        32'h0);
        check("rst_mid_ready", 32'(bus.hready_resp), 32'd1);
        ref_mem[16] = old_word;
        exp_q.delete();
        pend_r = 1'b0;
        pend_w = 1'b0;
        @(posedge clk); #1;
        check("rst_hold_wen", 32'(sram_wen), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycle();
        check("post_rst_wen", 32'(s_wen), 32'h0);
        bus_cycle(1'b1, 1'b0, 32'h40, 3'd2, 32'h0);
        idle_cycle();
        check("rst_lost_write", s_rdata, old_word);

        // Randomized legal traffic over a small address window
        for (int i = 0; i < 600; i++) begin
            logic        v, w;
            logic [31:0] a;
            logic [2:0]  sz;
            v  = ($urandom_range(0, 9) < 8);
            w  = $urandom_range(0, 1) == 1;
            a  = 32'($urandom_range(0, 63));
            sz = 3'($urandom_range(0, 2));
            bus_cycle(v, w, a, sz, $urandom);
        end
        repeat (3) idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
